// File: rtl/maze_job_sched.sv
// maze_job_sched: round-robin front end that shares one serial maze solver
// between N_REQ requesters. A granted requester streams its maze as one
// unbroken burst, the solver's reply is forwarded back to it with a last
// flag, and a watchdog recovers a hung solver with a timeout failure beat.
module maze_job_sched #(
  parameter int N_REQ     = 2,
  parameter int MAZE_BITS = 225,
  parameter int TIMEOUT   = 1023
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] mz_bit,
  output logic [N_REQ-1:0] gnt,
  output logic             sv_rst_n,
  output logic             sv_in_valid,
  output logic             sv_maze,
  input  logic             sv_out_valid,
  input  logic             sv_maze_not_valid,
  input  logic [3:0]       sv_out_x,
  input  logic [3:0]       sv_out_y,
  output logic [N_REQ-1:0] rsp_valid,
  output logic [3:0]       rsp_x,
  output logic [3:0]       rsp_y,
  output logic             rsp_fail,
  output logic             rsp_timeout,
  output logic             rsp_last
);

  localparam int SW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int LW = $clog2(MAZE_BITS);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [LW-1:0] LD_END = LW'(MAZE_BITS - 1);
  localparam logic [WW-1:0] WD_END = WW'(TIMEOUT - 1);
  localparam logic [SW-1:0] LAST_RST = SW'(N_REQ - 1);

  typedef enum logic [2:0] {IDLE, LOAD, WAIT, DRAIN, RECOVER} state_t;

  state_t           state_q, state_d;
  logic [SW-1:0]    sel_q, sel_d;
  logic [SW-1:0]    last_q, last_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [LW-1:0]    ld_cnt_q, ld_cnt_d;
  logic [WW-1:0]    wd_q, wd_d;
  logic [1:0]       rc_q, rc_d;
  logic             sv_rst_n_q, sv_rst_n_d;
  logic             sv_in_valid_q, sv_in_valid_d;
  logic             sv_maze_q, sv_maze_d;
  // one-entry holding register between solver and response port
  logic             hold_v_q, hold_v_d;
  logic [3:0]       hold_x_q, hold_x_d;
  logic [3:0]       hold_y_q, hold_y_d;
  logic             hold_fail_q, hold_fail_d;
  logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [3:0]       rsp_x_q, rsp_x_d;
  logic [3:0]       rsp_y_q, rsp_y_d;
  logic             rsp_fail_q, rsp_fail_d;
  logic             rsp_timeout_q, rsp_timeout_d;
  logic             rsp_last_q, rsp_last_d;

  logic [SW-1:0]    pick;
  logic             found;

  // round-robin pick: first requesting index after last, wrapping
  always_comb begin
    int            idx;
    logic [SW-1:0] idx_s;
    pick  = sel_q;
    found = 1'b0;
    idx   = 0;
    idx_s = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx   = (int'(last_q) + i) % N_REQ;
      idx_s = SW'(idx);
      if (!found && req[idx_s]) begin
        found = 1'b1;
        pick  = idx_s;
      end
    end
  end

  // next-state and registered-output logic
  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    last_d        = last_q;
    gnt_d         = gnt_q;
    ld_cnt_d      = ld_cnt_q;
    wd_d          = wd_q;
    rc_d          = rc_q;
    sv_rst_n_d    = 1'b1;
    sv_in_valid_d = 1'b0;
    sv_maze_d     = 1'b0;
    hold_v_d      = hold_v_q;
    hold_x_d      = hold_x_q;
    hold_y_d      = hold_y_q;
    hold_fail_d   = hold_fail_q;
    rsp_valid_d   = '0;
    rsp_x_d       = 4'd0;
    rsp_y_d       = 4'd0;
    rsp_fail_d    = 1'b0;
    rsp_timeout_d = 1'b0;
    rsp_last_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (found) begin
          sel_d       = pick;
          gnt_d       = '0;
          gnt_d[pick] = 1'b1;
          ld_cnt_d    = '0;
          state_d     = LOAD;
        end
      end
      LOAD: begin
        // burst runs to completion regardless of req
        sv_maze_d     = mz_bit[sel_q];
        sv_in_valid_d = 1'b1;
        ld_cnt_d      = ld_cnt_q + 1'b1;
        if (ld_cnt_q == LD_END) begin
          gnt_d   = '0;
          wd_d    = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        wd_d = wd_q + 1'b1;
        if (sv_out_valid) begin
          // failure beats are stored already zeroed
          hold_v_d    = 1'b1;
          hold_fail_d = sv_maze_not_valid;
          hold_x_d    = sv_maze_not_valid ? 4'd0 : sv_out_x;
          hold_y_d    = sv_maze_not_valid ? 4'd0 : sv_out_y;
          state_d     = DRAIN;
        end else if (wd_q == WD_END) begin
          rc_d    = 2'd0;
          state_d = RECOVER;
        end
      end
      DRAIN: begin
        if (rsp_last_q || !hold_v_q) begin
          // final beat is on the port this cycle; the job is done
          last_d   = sel_q;
          hold_v_d = 1'b0;
          state_d  = IDLE;
        end else begin
          rsp_valid_d[sel_q] = 1'b1;
          rsp_x_d            = hold_x_q;
          rsp_y_d            = hold_y_q;
          rsp_fail_d         = hold_fail_q;
          rsp_last_d         = hold_fail_q || !sv_out_valid;
          if (hold_fail_q || !sv_out_valid) begin
            hold_v_d = 1'b0;
          end else begin
            hold_fail_d = sv_maze_not_valid;
            hold_x_d    = sv_maze_not_valid ? 4'd0 : sv_out_x;
            hold_y_d    = sv_maze_not_valid ? 4'd0 : sv_out_y;
          end
        end
      end
      RECOVER: begin
        // two cycles of solver reset, then the timeout beat, then idle
        rc_d = rc_q + 1'b1;
        if (rc_q < 2'd2) begin
          sv_rst_n_d = 1'b0;
        end else if (rc_q == 2'd2) begin
          rsp_valid_d[sel_q] = 1'b1;
          rsp_fail_d         = 1'b1;
          rsp_timeout_d      = 1'b1;
          rsp_last_d         = 1'b1;
        end else begin
          last_d  = sel_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      sel_q         <= '0;
      last_q        <= LAST_RST;
      gnt_q         <= '0;
      ld_cnt_q      <= '0;
      wd_q          <= '0;
      rc_q          <= '0;
      sv_rst_n_q    <= 1'b0;
      sv_in_valid_q <= 1'b0;
      sv_maze_q     <= 1'b0;
      hold_v_q      <= 1'b0;
      hold_x_q      <= 4'd0;
      hold_y_q      <= 4'd0;
      hold_fail_q   <= 1'b0;
      rsp_valid_q   <= '0;
      rsp_x_q       <= 4'd0;
      rsp_y_q       <= 4'd0;
      rsp_fail_q    <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_last_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      last_q        <= last_d;
      gnt_q         <= gnt_d;
      ld_cnt_q      <= ld_cnt_d;
      wd_q          <= wd_d;
      rc_q          <= rc_d;
      sv_rst_n_q    <= sv_rst_n_d;
      sv_in_valid_q <= sv_in_valid_d;
      sv_maze_q     <= sv_maze_d;
      hold_v_q      <= hold_v_d;
      hold_x_q      <= hold_x_d;
      hold_y_q      <= hold_y_d;
      hold_fail_q   <= hold_fail_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_x_q       <= rsp_x_d;
      rsp_y_q       <= rsp_y_d;
      rsp_fail_q    <= rsp_fail_d;
      rsp_timeout_q <= rsp_timeout_d;
      rsp_last_q    <= rsp_last_d;
    end
  end

  assign gnt         = gnt_q;
  assign sv_rst_n    = sv_rst_n_q;
  assign sv_in_valid = sv_in_valid_q;
  assign sv_maze     = sv_maze_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_x       = rsp_x_q;
  assign rsp_y       = rsp_y_q;
  assign rsp_fail    = rsp_fail_q;
  assign rsp_timeout = rsp_timeout_q;
  assign rsp_last    = rsp_last_q;

endmodule

// File: tb/tb_maze_job_sched.sv
// Bench for maze_job_sched: behavioral requesters and solver, with a
// scoreboard of expected response beats (value and arrival cycle) and a
// queue of maze bits to check the burst reaching the solver.
module tb_maze_job_sched;
  localparam int N  = 2;
  localparam int MB = 225;
  localparam int TO = 1023;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req, mz_bit, gnt, rsp_valid;
  logic         sv_rst_n, sv_in_valid, sv_maze, sv_out_valid, sv_maze_not_valid;
  logic [3:0]   sv_out_x, sv_out_y, rsp_x, rsp_y;
  logic         rsp_fail, rsp_timeout, rsp_last;

  maze_job_sched #(.N_REQ(N), .MAZE_BITS(MB), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .mz_bit(mz_bit), .gnt(gnt),
    .sv_rst_n(sv_rst_n), .sv_in_valid(sv_in_valid), .sv_maze(sv_maze),
    .sv_out_valid(sv_out_valid), .sv_maze_not_valid(sv_maze_not_valid),
    .sv_out_x(sv_out_x), .sv_out_y(sv_out_y), .rsp_valid(rsp_valid),
    .rsp_x(rsp_x), .rsp_y(rsp_y), .rsp_fail(rsp_fail),
    .rsp_timeout(rsp_timeout), .rsp_last(rsp_last)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [N-1:0] v;
    logic [3:0]   x, y;
    logic         f, t, l;
    int           c;
  } beat_t;

  beat_t expq[$];
  logic  bitq[$];
  int    checks = 0, failures = 0;

  // solver behaviour: 0 path, 1 no path, 2 never answers
  int         sol_mode = 0, sol_delay = 0, path_len = 1;
  logic [3:0] path_x[0:31], path_y[0:31];
  logic       spur_on = 1'b0;

  // observations
  int gnt_hist[$], gap_hist[$];
  int gnt_rise_cyc = 0, gnt_len = 0, iv_start = 0, iv_len = 0, iv_runs = 0;
  int lo_start = 0, lo_len = 0, done_cnt = 0, beats = 0, last_rsp_cyc = -1000;
  int m_w_cyc = 0, cur_gnt = 0;
  logic [3:0] last_x = 4'd0, last_y = 4'd0;

  // path of len beats ending at (1,1): along y=13 from x=13, then down x=1
  task automatic set_path(input int len);
    int k;
    path_len = len;
    for (int i = 0; i < len; i++) begin
      k = 25 - len + i;
      if (k < 12) begin path_x[i] = 4'(13 - k); path_y[i] = 4'd13; end
      else        begin path_x[i] = 4'd1;       path_y[i] = 4'(25 - k); end
    end
  endtask

  task automatic monitor();
    logic [N-1:0] pg = '0;
    logic piv = 1'b0, psrn = 1'b0, b;
    int m_ld = 0, m_wait = 0, m_idx = 0;
    bit m_arm = 1'b0;
    beat_t e;
    forever begin
      @(negedge clk);
      if (gnt != '0 && pg == '0) begin
        for (int r = 0; r < N; r++) if (gnt[r]) cur_gnt = r;
        gnt_hist.push_back(cur_gnt);
        gap_hist.push_back(cyc - last_rsp_cyc);
        gnt_rise_cyc = cyc; gnt_len = 0; beats = 0;
      end
      if (gnt != '0) gnt_len++;
      pg = gnt;
      if (sv_in_valid && !piv) begin iv_start = cyc; iv_len = 0; iv_runs++; end
      if (sv_in_valid) iv_len++;
      piv = sv_in_valid;
      if (!rst && !sv_rst_n) begin
        if (psrn) begin lo_start = cyc; lo_len = 0; end
        lo_len++;
      end
      psrn = sv_rst_n;

      if (rsp_valid != '0) begin
        checks++;
        if (expq.size() == 0) begin
          failures++;
          $display("FAIL rsp_unexpected got v=%b x=%0d y=%0d f=%b t=%b l=%b cyc=%0d want none",
                   rsp_valid, rsp_x, rsp_y, rsp_fail, rsp_timeout, rsp_last, cyc);
        end else begin
          e = expq.pop_front();
          if ({rsp_valid, rsp_x, rsp_y, rsp_fail, rsp_timeout, rsp_last} !== {e.v, e.x, e.y, e.f, e.t, e.l}
              || cyc != e.c) begin
            failures++;
            $display("FAIL rsp_beat got v=%b x=%0d y=%0d f=%b t=%b l=%b cyc=%0d want v=%b x=%0d y=%0d f=%b t=%b l=%b cyc=%0d",
                     rsp_valid, rsp_x, rsp_y, rsp_fail, rsp_timeout, rsp_last, cyc,
                     e.v, e.x, e.y, e.f, e.t, e.l, e.c);
          end
        end
        beats++;
        if (rsp_last) begin done_cnt++; last_rsp_cyc = cyc; last_x = rsp_x; last_y = rsp_y; end
      end

      sv_out_valid = 1'b0; sv_maze_not_valid = 1'b0; sv_out_x = 4'd0; sv_out_y = 4'd0;
      if (rst) expq.delete();
      if (!sv_rst_n) begin
        bitq.delete(); m_ld = 0; m_arm = 1'b0;
      end else begin
        if (sv_in_valid) begin
          checks++;
          if (bitq.size() == 0) begin
            failures++;
            $display("FAIL maze_bit got extra bit %b want none", sv_maze);
          end else begin
            b = bitq.pop_front();
            if (sv_maze !== b) begin
              failures++;
              $display("FAIL maze_bit got %b want %b at load bit %0d", sv_maze, b, m_ld);
            end
          end
          m_ld++;
          if (m_ld == MB) begin
            m_ld = 0; m_w_cyc = cyc;
            if (sol_mode == 2) begin
              e.v = '0; e.v[cur_gnt] = 1'b1; e.x = 4'd0; e.y = 4'd0;
              e.f = 1'b1; e.t = 1'b1; e.l = 1'b1; e.c = cyc + TO + 3;
              expq.push_back(e);
            end else begin
              m_arm = 1'b1; m_wait = sol_delay; m_idx = 0;
            end
          end
        end
        if (spur_on) begin
          sv_out_valid = 1'b1; sv_maze_not_valid = 1'($urandom_range(0, 1));
          sv_out_x = 4'($urandom_range(0, 15)); sv_out_y = 4'($urandom_range(0, 15));
        end else if (m_arm) begin
          if (m_wait > 0) m_wait--;
          else begin
            sv_out_valid = 1'b1;
            e.v = '0; e.v[cur_gnt] = 1'b1; e.t = 1'b0; e.c = cyc + 2;
            if (sol_mode == 1) begin
              sv_maze_not_valid = 1'b1;
              sv_out_x = 4'($urandom_range(1, 15)); sv_out_y = 4'($urandom_range(1, 15));
              e.x = 4'd0; e.y = 4'd0; e.f = 1'b1; e.l = 1'b1; m_arm = 1'b0;
            end else begin
              sv_out_x = path_x[m_idx]; sv_out_y = path_y[m_idx];
              e.x = path_x[m_idx]; e.y = path_y[m_idx]; e.f = 1'b0;
              e.l = (m_idx == path_len - 1);
              m_idx++;
              if (m_idx == path_len) m_arm = 1'b0;
            end
            expq.push_back(e);
          end
        end
      end

      for (int r = 0; r < N; r++) begin
        b = 1'($urandom_range(0, 1));
        mz_bit[r] = b;
        if (gnt[r]) bitq.push_back(b);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({gnt, sv_rst_n, sv_in_valid, sv_maze, rsp_valid, rsp_x, rsp_y, rsp_fail, rsp_timeout, rsp_last} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got gnt=%b srn=%b iv=%b rv=%b want all 0", gnt, sv_rst_n, sv_in_valid, rsp_valid);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({sv_rst_n, gnt, sv_in_valid} !== {1'b1, {N{1'b0}}, 1'b0}) begin
      failures++;
      $display("FAIL reset_release got srn=%b gnt=%b iv=%b want srn=1 gnt=0 iv=0", sv_rst_n, gnt, sv_in_valid);
    end
  endtask

  task automatic test_alternate();
    int base, tgt;
    sol_mode = 0; sol_delay = 0; set_path(3);
    base = gnt_hist.size(); tgt = done_cnt + 4;
    @(negedge clk); req = 2'b11;
    for (int k = 0; k < 3000 && gnt_hist.size() < base + 4; k++) @(negedge clk);
    req = 2'b00;
    for (int k = 0; k < 2000 && done_cnt < tgt; k++) @(negedge clk);
    checks++;
    if (done_cnt < tgt || gnt_hist.size() != base + 4) begin
      failures++;
      $display("FAIL alt_jobs got grants=%0d done=%0d want grants=%0d done=%0d",
               gnt_hist.size() - base, done_cnt, 4, tgt);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (gnt_hist[base + i] != i % 2) begin
          failures++;
          $display("FAIL alt_order job %0d got req %0d want %0d", i, gnt_hist[base + i], i % 2);
        end
      end
      for (int i = 1; i < 4; i++) begin
        checks++;
        if (gap_hist[base + i] != 2) begin
          failures++;
          $display("FAIL alt_gap job %0d got %0d want 2", i, gap_hist[base + i]);
        end
      end
    end
  endtask

  task automatic test_single_path();
    int base, tgt, runs0, req_cyc;
    sol_mode = 0; sol_delay = 3; set_path(25);
    base = gnt_hist.size(); tgt = done_cnt + 1; runs0 = iv_runs;
    @(negedge clk); req = 2'b01; req_cyc = cyc;
    for (int k = 0; k < 20 && gnt_hist.size() == base; k++) @(negedge clk);
    req = 2'b00;
    for (int k = 0; k < 2000 && done_cnt < tgt; k++) @(negedge clk);
    checks++;
    if (done_cnt < tgt) begin
      failures++; $display("FAIL single_done got %0d want %0d", done_cnt, tgt);
    end
    checks++;
    if (gnt_rise_cyc - req_cyc != 1 || gnt_len != MB) begin
      failures++;
      $display("FAIL single_gnt got lat=%0d len=%0d want lat=1 len=%0d", gnt_rise_cyc - req_cyc, gnt_len, MB);
    end
    checks++;
    if (iv_start - req_cyc != 2 || iv_len != MB || iv_runs != runs0 + 1) begin
      failures++;
      $display("FAIL single_in_valid got lat=%0d len=%0d runs=%0d want lat=2 len=%0d runs=1",
               iv_start - req_cyc, iv_len, iv_runs - runs0, MB);
    end
    checks++;
    if (beats != 25 || last_x != 4'd1 || last_y != 4'd1) begin
      failures++;
      $display("FAIL single_stream got beats=%0d last=(%0d,%0d) want beats=25 last=(1,1)", beats, last_x, last_y);
    end
  endtask

  task automatic test_blocked();
    int base, tgt;
    sol_mode = 1; sol_delay = 5;
    base = gnt_hist.size(); tgt = done_cnt + 1;
    @(negedge clk); req = 2'b01;
    for (int k = 0; k < 20 && gnt_hist.size() == base; k++) @(negedge clk);
    req = 2'b00;
    for (int k = 0; k < 2000 && done_cnt < tgt; k++) @(negedge clk);
    checks++;
    if (done_cnt < tgt || beats != 1) begin
      failures++; $display("FAIL blocked_beats got done=%0d beats=%0d want done=%0d beats=1", done_cnt, beats, tgt);
    end
  endtask

  task automatic test_timeout();
    int base, tgt;
    sol_mode = 2;
    base = gnt_hist.size(); tgt = done_cnt + 1;
    @(negedge clk); req = 2'b10;
    for (int k = 0; k < 20 && gnt_hist.size() == base; k++) @(negedge clk);
    req = 2'b00;
    for (int k = 0; k < 2000 && done_cnt < tgt; k++) @(negedge clk);
    checks++;
    if (done_cnt < tgt || beats != 1) begin
      failures++; $display("FAIL timeout_beat got done=%0d beats=%0d want done=%0d beats=1", done_cnt, beats, tgt);
    end
    checks++;
    if (lo_len != 2 || lo_start - m_w_cyc != TO + 1) begin
      failures++;
      $display("FAIL timeout_sv_rst got len=%0d start=%0d want len=2 start=%0d", lo_len, lo_start - m_w_cyc, TO + 1);
    end
    // the next job must run normally after recovery
    sol_mode = 0; sol_delay = 2; set_path(4);
    base = gnt_hist.size(); tgt = done_cnt + 1;
    @(negedge clk); req = 2'b01;
    for (int k = 0; k < 20 && gnt_hist.size() == base; k++) @(negedge clk);
    req = 2'b00;
    for (int k = 0; k < 2000 && done_cnt < tgt; k++) @(negedge clk);
    checks++;
    if (done_cnt < tgt || beats != 4) begin
      failures++; $display("FAIL after_timeout got done=%0d beats=%0d want done=%0d beats=4", done_cnt, beats, tgt);
    end
  endtask

  task automatic test_rst_abort();
    int base, tgt, runs0, done0, req_cyc;
    sol_mode = 0; sol_delay = 0; set_path(5);
    base = gnt_hist.size(); runs0 = iv_runs;
    @(negedge clk); req = 2'b10;
    for (int k = 0; k < 400 && !(iv_runs > runs0 && iv_len >= 100); k++) @(negedge clk);
    done0 = done_cnt;
    @(posedge clk); #2 rst = 1'b1;
    #1;
    checks++;
    if ({gnt, sv_rst_n, sv_in_valid, sv_maze, rsp_valid, rsp_x, rsp_y, rsp_fail, rsp_timeout, rsp_last} !== '0) begin
      failures++;
      $display("FAIL abort_async got gnt=%b srn=%b iv=%b rv=%b want all 0", gnt, sv_rst_n, sv_in_valid, rsp_valid);
    end
    repeat (3) @(negedge clk);
    sol_mode = 1; sol_delay = 1;
    base = gnt_hist.size(); tgt = done_cnt + 1;
    rst = 1'b0; req = 2'b11; req_cyc = cyc;
    for (int k = 0; k < 20 && gnt_hist.size() == base; k++) @(negedge clk);
    req = 2'b00;
    checks++;
    if (gnt_hist.size() == base || gnt_hist[base] != 0 || gnt_rise_cyc - req_cyc != 1) begin
      failures++;
      $display("FAIL abort_first_gnt got grants=%0d lat=%0d want req 0 lat=1", gnt_hist.size() - base, gnt_rise_cyc - req_cyc);
    end
    checks++;
    if (done_cnt != done0) begin
      failures++; $display("FAIL abort_no_rsp got %0d responses want 0", done_cnt - done0);
    end
    for (int k = 0; k < 2000 && done_cnt < tgt; k++) @(negedge clk);
    checks++;
    if (done_cnt < tgt || beats != 1) begin
      failures++; $display("FAIL abort_next_job got done=%0d beats=%0d want done=%0d beats=1", done_cnt, beats, tgt);
    end
  endtask

  task automatic test_spurious();
    int base, tgt, runs0;
    sol_mode = 0; sol_delay = 4; set_path(6);
    base = gnt_hist.size(); tgt = done_cnt + 1; runs0 = iv_runs;
    @(negedge clk); req = 2'b01;
    for (int k = 0; k < 20 && gnt_hist.size() == base; k++) @(negedge clk);
    req = 2'b00;
    for (int k = 0; k < 400 && !(iv_runs > runs0 && iv_len >= 50); k++) @(negedge clk);
    spur_on = 1'b1;
    repeat (3) @(negedge clk);
    spur_on = 1'b0;
    for (int k = 0; k < 2000 && done_cnt < tgt; k++) @(negedge clk);
    checks++;
    if (done_cnt < tgt || beats != 6 || last_x != 4'd1 || last_y != 4'd1) begin
      failures++;
      $display("FAIL spurious got done=%0d beats=%0d last=(%0d,%0d) want done=%0d beats=6 last=(1,1)",
               done_cnt, beats, last_x, last_y, tgt);
    end
  endtask

  initial begin
    rst = 1'b1; req = '0; mz_bit = '0;
    sv_out_valid = 1'b0; sv_maze_not_valid = 1'b0; sv_out_x = 4'd0; sv_out_y = 4'd0;
    fork
      monitor();
    join_none
    test_reset();
    test_alternate();
    test_single_path();
    test_blocked();
    test_timeout();
    test_rst_abort();
    test_spurious();
    repeat (5) @(negedge clk);
    checks++;
    if (expq.size() != 0) begin
      failures++; $display("FAIL leftover_beats got %0d pending want 0", expq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout sim time limit reached");
    $fatal(1, "time limit");
  end

endmodule
